// File: rtl/ahb_pkg.sv
// Shared AHB encodings: transfer types, slave responses and arbiter FSM states.
package ahb_pkg;

    localparam int MST_IDX_W = 2;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [1:0] {
        ARB_PARK   = 2'b00,
        ARB_GRANT  = 2'b01,
        ARB_LOCKED = 2'b10
    } arb_state_e;

endpackage

// File: rtl/ahb_arbiter_rr_pick.sv
// Round-robin priority search: first requester after the pointer, wrapping.
module rr_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0]                   req_i,
    input  logic [ahb_pkg::MST_IDX_W-1:0]  ptr_i,
    output logic [N-1:0]                   gnt_o,
    output logic                           vld_o
);

    // Scan ptr+1 .. ptr+N (mod N); the owner itself is checked last.
    always_comb begin
        int idx;
        gnt_o = '0;
        vld_o = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!vld_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                vld_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter in front of the bridge: round-robin grant, locked
// transfers, burst length limit and parking on a default master.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MST   = 3,
    parameter int MAX_BEATS = 16,
    parameter int DEF_MST   = 0
) (
    input  logic               Hclk,
    input  logic               Hresetn,
    input  logic [NUM_MST-1:0] Hbusreq,
    input  logic [NUM_MST-1:0] Hlock,
    input  logic [1:0]         Htrans,
    input  logic               Hreadyin,
    output logic [NUM_MST-1:0] Hgrant,
    output logic [1:0]         Hmaster,
    output logic               Hmastlock
);

    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam logic [NUM_MST-1:0]   DEF_OH  = {{(NUM_MST-1){1'b0}}, 1'b1} << DEF_MST;
    localparam logic [MST_IDX_W-1:0] DEF_IDX = MST_IDX_W'(DEF_MST);

    arb_state_e            state_q, state_d;
    logic [NUM_MST-1:0]    grant_q, grant_d;
    logic [MST_IDX_W-1:0]  owner_q, owner_d;   // granted index, doubles as RR pointer
    logic [MST_IDX_W-1:0]  master_q;
    logic                  mastlock_q;
    logic [BW-1:0]         beats_q;

    logic [NUM_MST-1:0]    win_oh;
    logic                  win_vld;
    logic [MST_IDX_W-1:0]  win_idx;
    logic                  own_lock, arb_pt, beat;
    htrans_e               htrans;

    rr_pick #(.N(NUM_MST)) u_rr_pick (
        .req_i (Hbusreq),
        .ptr_i (owner_q),
        .gnt_o (win_oh),
        .vld_o (win_vld)
    );

    // Arbitration point detection and next grant selection.
    always_comb begin
        htrans   = htrans_e'(Htrans);
        beat     = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
        own_lock = Hbusreq[owner_q] & Hlock[owner_q];
        win_idx  = '0;
        for (int i = 0; i < NUM_MST; i++)
            if (win_oh[i]) win_idx = MST_IDX_W'(i);

        if (state_q == ARB_LOCKED)
            arb_pt = !Hlock[owner_q] && (htrans == HTRANS_IDLE);
        else
            arb_pt = (htrans == HTRANS_IDLE) || (htrans == HTRANS_NONSEQ) ||
                     (state_q == ARB_PARK) || (beats_q == BW'(MAX_BEATS));

        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        if (arb_pt) begin
            if (own_lock) begin
                state_d = ARB_LOCKED;
            end else if (win_vld) begin
                state_d = ARB_GRANT;
                grant_d = win_oh;
                owner_d = win_idx;
            end else begin
                state_d = ARB_PARK;
                grant_d = DEF_OH;
                owner_d = DEF_IDX;
            end
        end
    end

    // All arbiter state advances only on Hready-qualified edges.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q    <= ARB_PARK;
            grant_q    <= DEF_OH;
            owner_q    <= DEF_IDX;
            master_q   <= DEF_IDX;
            mastlock_q <= 1'b0;
            beats_q    <= '0;
        end else if (Hreadyin) begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            master_q   <= owner_q;
            mastlock_q <= Hlock[owner_q];
            if (grant_d != grant_q)
                beats_q <= '0;
            else if (beat && beats_q != BW'(MAX_BEATS))
                beats_q <= beats_q + 1'b1;
        end
    end

    assign Hgrant    = grant_q;
    assign Hmaster   = master_q;
    assign Hmastlock = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter with NUM_MST=3, MAX_BEATS=16, DEF_MST=0.
module tb_ahb_arbiter;

    logic       Hclk = 1'b0;
    logic       Hresetn = 1'b1;
    logic [2:0] Hbusreq = 3'b000;
    logic [2:0] Hlock = 3'b000;
    logic [1:0] Htrans = 2'b00;
    logic       Hreadyin = 1'b1;
    logic [2:0] Hgrant;
    logic [1:0] Hmaster;
    logic       Hmastlock;

    int checks = 0;
    int fails  = 0;

    localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

    ahb_arbiter #(.NUM_MST(3), .MAX_BEATS(16), .DEF_MST(0)) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Hbusreq   (Hbusreq),
        .Hlock     (Hlock),
        .Htrans    (Htrans),
        .Hreadyin  (Hreadyin),
        .Hgrant    (Hgrant),
        .Hmaster   (Hmaster),
        .Hmastlock (Hmastlock)
    );

    always #5 Hclk = ~Hclk;

    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    task automatic do_reset();
        Hbusreq = 3'b000; Hlock = 3'b000; Htrans = T_IDLE; Hreadyin = 1'b1;
        Hresetn = 1'b0;
        step();
        Hresetn = 1'b1;
    endtask

    task automatic test_reset();
        #2 Hresetn = 1'b0;
        #1;
        checks++; if (Hgrant !== 3'b001) begin fails++; $display("FAIL rst_grant got=%b exp=001", Hgrant); end
        checks++; if (Hmaster !== 2'd0) begin fails++; $display("FAIL rst_master got=%0d exp=0", Hmaster); end
        checks++; if (Hmastlock !== 1'b0) begin fails++; $display("FAIL rst_mastlock got=%b exp=0", Hmastlock); end
        step();
        Hresetn = 1'b1;
        step(); step();
        checks++; if (Hgrant !== 3'b001) begin fails++; $display("FAIL park_grant got=%b exp=001", Hgrant); end
        checks++; if (Hmaster !== 2'd0) begin fails++; $display("FAIL park_master got=%0d exp=0", Hmaster); end
        checks++; if (Hmastlock !== 1'b0) begin fails++; $display("FAIL park_mastlock got=%b exp=0", Hmastlock); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g [4] = '{3'b010, 3'b100, 3'b001, 3'b010};
        logic [1:0] exp_m [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        do_reset();
        Hbusreq = 3'b111; Htrans = T_NONSEQ;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (Hgrant !== exp_g[k]) begin fails++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, Hgrant, exp_g[k]); end
            checks++; if (Hmaster !== exp_m[k]) begin fails++; $display("FAIL rr_master[%0d] got=%0d exp=%0d", k, Hmaster, exp_m[k]); end
        end
    endtask

    task automatic test_burst_limit();
        logic [2:0] exp;
        do_reset();
        Hbusreq = 3'b011; Htrans = T_NONSEQ;
        step();
        checks++; if (Hgrant !== 3'b010) begin fails++; $display("FAIL burst_start got=%b exp=010", Hgrant); end
        Htrans = T_SEQ;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp = (k <= 16) ? 3'b010 : 3'b001;
            checks++; if (Hgrant !== exp) begin fails++; $display("FAIL burst_grant[%0d] got=%b exp=%b", k, Hgrant, exp); end
            if (k == 18) begin
                checks++; if (Hmaster !== 2'd0) begin fails++; $display("FAIL burst_master got=%0d exp=0", Hmaster); end
            end
            // Owner drops its request mid-burst: grant must hold.
            if (k == 5) Hbusreq = 3'b001;
            // Stall mid-burst: nothing moves, beat count frozen.
            if (k == 8) begin
                Hreadyin = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    Hbusreq = (s % 2 == 0) ? 3'b100 : 3'b110;
                    step();
                    checks++; if (Hgrant !== 3'b010) begin fails++; $display("FAIL stall_grant[%0d] got=%b exp=010", s, Hgrant); end
                end
                Hreadyin = 1'b1; Hbusreq = 3'b001;
            end
        end
    endtask

    task automatic test_lock();
        do_reset();
        Hbusreq = 3'b111; Hlock = 3'b100; Htrans = T_NONSEQ;
        step(); step(); step();
        checks++; if (Hgrant !== 3'b100) begin fails++; $display("FAIL lock_grant got=%b exp=100", Hgrant); end
        checks++; if (Hmaster !== 2'd2) begin fails++; $display("FAIL lock_master got=%0d exp=2", Hmaster); end
        checks++; if (Hmastlock !== 1'b1) begin fails++; $display("FAIL lock_mastlock got=%b exp=1", Hmastlock); end
        Htrans = T_SEQ;
        for (int k = 0; k < 4; k++) step();
        checks++; if (Hgrant !== 3'b100) begin fails++; $display("FAIL lock_hold got=%b exp=100", Hgrant); end
        Htrans = T_IDLE;
        step();
        checks++; if (Hgrant !== 3'b100) begin fails++; $display("FAIL lock_idle_hold got=%b exp=100", Hgrant); end
        Hlock = 3'b000; Htrans = T_SEQ;
        step();
        checks++; if (Hgrant !== 3'b100) begin fails++; $display("FAIL lock_seq_hold got=%b exp=100", Hgrant); end
        checks++; if (Hmastlock !== 1'b0) begin fails++; $display("FAIL lock_drop got=%b exp=0", Hmastlock); end
        Htrans = T_IDLE;
        step();
        checks++; if (Hgrant !== 3'b001) begin fails++; $display("FAIL lock_exit got=%b exp=001", Hgrant); end
        step();
        checks++; if (Hmaster !== 2'd0) begin fails++; $display("FAIL lock_exit_master got=%0d exp=0", Hmaster); end
    endtask

    task automatic test_hready_stall();
        logic [2:0] reqs [5] = '{3'b101, 3'b100, 3'b001, 3'b111, 3'b110};
        do_reset();
        Hbusreq = 3'b010; Htrans = T_NONSEQ;
        step(); step();
        checks++; if (Hgrant !== 3'b010 || Hmaster !== 2'd1) begin fails++; $display("FAIL stall_pre got=%b/%0d exp=010/1", Hgrant, Hmaster); end
        Hreadyin = 1'b0;
        for (int k = 0; k < 5; k++) begin
            Hbusreq = reqs[k];
            step();
            checks++; if (Hgrant !== 3'b010 || Hmaster !== 2'd1) begin fails++; $display("FAIL freeze[%0d] got=%b/%0d exp=010/1", k, Hgrant, Hmaster); end
        end
        Hreadyin = 1'b1; Hbusreq = 3'b101;
        step();
        checks++; if (Hgrant !== 3'b100) begin fails++; $display("FAIL unfreeze_grant got=%b exp=100", Hgrant); end
        step();
        checks++; if (Hgrant !== 3'b001 || Hmaster !== 2'd2) begin fails++; $display("FAIL unfreeze_next got=%b/%0d exp=001/2", Hgrant, Hmaster); end
    endtask

    task automatic test_async_reset();
        do_reset();
        Hbusreq = 3'b011; Htrans = T_NONSEQ;
        step();
        Htrans = T_SEQ;
        step(); step(); step();
        checks++; if (Hgrant !== 3'b010 || Hmaster !== 2'd1) begin fails++; $display("FAIL areset_pre got=%b/%0d exp=010/1", Hgrant, Hmaster); end
        #2 Hresetn = 1'b0;
        #1 Hresetn = 1'b1;
        #1;
        checks++; if (Hgrant !== 3'b001) begin fails++; $display("FAIL areset_grant got=%b exp=001", Hgrant); end
        checks++; if (Hmaster !== 2'd0) begin fails++; $display("FAIL areset_master got=%0d exp=0", Hmaster); end
        checks++; if (Hmastlock !== 1'b0) begin fails++; $display("FAIL areset_mastlock got=%b exp=0", Hmastlock); end
        Hbusreq = 3'b100;
        step();
        checks++; if (Hgrant !== 3'b100) begin fails++; $display("FAIL areset_rearb got=%b exp=100", Hgrant); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst_limit();
        test_lock();
        test_hready_stall();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter NUM_MST, default 3, number of AHB masters sharing the bridge; legal range 2..4.
REQ-002 Parameter MAX_BEATS, default 16, beats one owner may hold the bus before forced re-arbitration.
REQ-003 Parameter DEF_MST, default 0, index of the default (park) master.
REQ-004 Hclk  in  1  single clock; all state updates on its rising edge.
REQ-005 Hresetn  in  1  reset, asynchronous, active-low.
REQ-006 Hbusreq  in  NUM_MST  per-master bus request.
REQ-007 Hlock  in  NUM_MST  per-master locked-transfer request.
REQ-008 Htrans  in  2  transfer type of the current address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-009 Hreadyin  in  1  bus ready, taken from the bridge Hreadyout.
REQ-010 Hgrant  out  NUM_MST  one-hot grant, registered.
REQ-011 Hmaster  out  2  index of the current address-phase owner, registered.
REQ-012 Hmastlock  out  1  current address-phase transfer is locked, registered.

Function
REQ-013 Hgrant SHALL be one-hot at all times, including immediately after reset.
REQ-014 Hgrant, Hmaster, Hmastlock, the FSM state and the beat counter SHALL update only on an edge where Hreadyin=1; with Hreadyin=0 all hold.
REQ-015 FSM states: PARK (no requests, DEF_MST granted), GRANT (unlocked owner), LOCKED (owner holds Hlock).
REQ-016 Arbitration point: Htrans is IDLE or NONSEQ, the FSM is in PARK, or the beat counter has reached MAX_BEATS; no re-arbitration while Htrans is SEQ or BUSY below the limit.
REQ-017 At an arbitration point the winner SHALL be the first requesting master in round-robin order starting at (last owner + 1) mod NUM_MST.
REQ-018 No requests at an arbitration point -> grant DEF_MST and enter PARK.
REQ-019 Owner with Hbusreq=1 and Hlock=1 at an arbitration point -> keep the grant and enter LOCKED; LOCKED exits only when that owner's Hlock=0 and Htrans=IDLE. The MAX_BEATS limit does not apply in LOCKED.
REQ-020 Hmaster and Hmastlock SHALL take the granted index and its Hlock on the first Hreadyin=1 edge after Hgrant changes: one Hready-qualified cycle of address-phase latency.
REQ-021 Beat counter: clears at every grant change; increments on each Hreadyin=1 edge with Htrans NONSEQ or SEQ; saturates at MAX_BEATS.
REQ-022 A request dropped by the current owner while Htrans=SEQ SHALL NOT release the grant before the next arbitration point.
REQ-023 Hbusreq bits at or above NUM_MST SHALL be ignored.

Reset
REQ-024 Hresetn=0 SHALL immediately force Hgrant=one-hot(DEF_MST), Hmaster=DEF_MST, Hmastlock=0, state=PARK, round-robin pointer=DEF_MST, beat counter=0, regardless of Hclk.
REQ-025 Reset asserted mid-burst or mid-lock SHALL abandon the transfer; the first post-reset arbitration uses only the current requests.

Structure
REQ-026 Htrans encodings and the FSM state encoding SHALL live in the shared package ahb_pkg, alongside those used by ahb_slave_interface.
REQ-027 The round-robin priority search SHALL be one combinational sub-module, rr_pick (inputs: request vector, pointer; output: one-hot winner plus valid).
REQ-028 ahb_arbiter SHALL sit in front of bridge_top: its Hreadyin comes from the bridge Hreadyout, and it drives no bridge datapath signal.

Verification
REQ-029 Reset release with Hbusreq=000 -> Hgrant=001, Hmaster=0, Hmastlock=0, state PARK.
REQ-030 Hbusreq=111 held, NONSEQ single transfers, Hreadyin=1 -> Hgrant sequence 010,100,001,010; Hmaster follows one cycle later.
REQ-031 Master 1 granted, Htrans NONSEQ then SEQ x20 with Hbusreq=011 -> re-arbitration after 16 beats; grant moves to master 0.
REQ-032 Master 2 with Hlock=1, Hbusreq=111 -> Hgrant stays 100 and Hmastlock=1 until Hlock=0 with IDLE, then 001.
REQ-033 Hreadyin=0 for 5 cycles while Hbusreq changes -> Hgrant, Hmaster and the counter remain frozen.
REQ-034 Hresetn pulsed low for 1 ns between edges during a SEQ burst -> outputs return to reset values immediately.
